// File: rtl/sound_mixer_if.sv
// Mixer voice inputs and mixed-output bundle.
// master drives voices and mute; slave is the mixer.
interface sound_mixer_if #(
  parameter int CHANNELS = 2,
  parameter int IN_W     = 8,
  parameter int VOL_W    = 4,
  parameter int OUT_W    = 16
);
  logic [CHANNELS*IN_W-1:0]  ch_sample;
  logic [CHANNELS-1:0]       ch_active;
  logic [CHANNELS*VOL_W-1:0] ch_vol;
  logic                      mute;
  logic [OUT_W-1:0]          audio_out;
  logic                      sample_tick;
  logic                      busy;
  logic                      clip;

  modport master (
    output ch_sample, ch_active, ch_vol, mute,
    input  audio_out, sample_tick, busy, clip
  );

  modport slave (
    input  ch_sample, ch_active, ch_vol, mute,
    output audio_out, sample_tick, busy, clip
  );
endinterface

// File: rtl/sound_mixer.sv
// Serial N-voice mixer: snapshot, scale, sum, saturate, offset-binary out.
// Optional MIXER_RAMP_EN: per-channel volume ramps one step per output tick.
module sound_mixer #(
  parameter int CHANNELS = 2,
  parameter int IN_W     = 8,
  parameter int VOL_W    = 4,
  parameter int OUT_W    = 16,
  parameter int TICK_DIV = 2178
) (
  input logic         clk,
  input logic         reset_n,
  sound_mixer_if.slave mix
);

  localparam int CW    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int P_W   = IN_W + VOL_W + 2;
  localparam int ACC_W = IN_W + VOL_W + 1 + $clog2(CHANNELS) + 1;
  localparam int SH    = OUT_W - IN_W - VOL_W;
  localparam int Y_W   = ACC_W + SH;

  localparam logic [IN_W-1:0]  MID_IN  = {1'b1, {(IN_W-1){1'b0}}};
  localparam logic [OUT_W-1:0] MID_OUT = {1'b1, {(OUT_W-1){1'b0}}};
  localparam logic signed [Y_W-1:0] YMAX = Y_W'((64'd1 << (OUT_W-1)) - 64'd1);
  localparam logic signed [Y_W-1:0] YMIN = ~YMAX;

  if (TICK_DIV <= CHANNELS + 3) begin : g_div_chk
    $error("sound_mixer: TICK_DIV must exceed CHANNELS+3");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_SNAP,
    S_ACCUM,
    S_CLAMP,
    S_OUT
  } state_t;

  state_t                    state_q;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [CW-1:0]             ch_q;
  logic [CHANNELS*IN_W-1:0]  samp_q;
  logic [CHANNELS-1:0]       act_q;
  logic [CHANNELS*VOL_W-1:0] vol_q;
  logic                      mute_q;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic [OUT_W-1:0]          y_q;
  logic                      clipn_q;
  logic [OUT_W-1:0]          audio_q;
  logic                      tick_q;
  logic                      clip_q;

  logic                      wrap_w;
  logic                      last_w;
  logic [IN_W-1:0]           samp_w;
  logic [VOL_W-1:0]          vol_w;
  logic                      act_w;
  logic signed [IN_W:0]      s_w;
  logic signed [P_W-1:0]     p_w;
  logic signed [Y_W-1:0]     ysh_w;
  logic [OUT_W-1:0]          ysat_w;
  logic                      sat_w;

  assign wrap_w = (cnt_q == CNT_W'(TICK_DIV - 1));
  assign cnt_d  = wrap_w ? '0 : cnt_q + CNT_W'(1);
  assign last_w = (ch_q == CW'(CHANNELS - 1));
  assign samp_w = samp_q[ch_q*IN_W +: IN_W];

`ifdef MIXER_RAMP_EN
  logic [CHANNELS*VOL_W-1:0] veff_q, veff_d;
  logic [VOL_W-1:0]          tgt_w, cur_w;

  // Ramp targets come from the snapshot of the sample just mixed
  always_comb begin
    veff_d = veff_q;
    tgt_w  = '0;
    cur_w  = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      tgt_w = act_q[i] ? vol_q[i*VOL_W +: VOL_W] : '0;
      cur_w = veff_q[i*VOL_W +: VOL_W];
      if (cur_w < tgt_w)
        veff_d[i*VOL_W +: VOL_W] = cur_w + VOL_W'(1);
      else if (cur_w > tgt_w)
        veff_d[i*VOL_W +: VOL_W] = cur_w - VOL_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n)
      veff_q <= '0;
    else if (state_q == S_OUT)
      veff_q <= veff_d;
  end

  assign vol_w = veff_q[ch_q*VOL_W +: VOL_W];
  assign act_w = 1'b1;
`else
  assign vol_w = vol_q[ch_q*VOL_W +: VOL_W];
  assign act_w = act_q[ch_q];
`endif

  always_comb begin
    s_w   = $signed({1'b0, samp_w}) - $signed({1'b0, MID_IN});
    p_w   = act_w ? P_W'(s_w) * P_W'($signed({1'b0, vol_w})) : '0;
    acc_d = acc_q + ACC_W'(p_w);
  end

  always_comb begin
    ysh_w  = Y_W'(acc_q) <<< SH;
    sat_w  = 1'b0;
    ysat_w = ysh_w[OUT_W-1:0];
    if (ysh_w > YMAX) begin
      sat_w  = 1'b1;
      ysat_w = YMAX[OUT_W-1:0];
    end else if (ysh_w < YMIN) begin
      sat_w  = 1'b1;
      ysat_w = YMIN[OUT_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ch_q    <= '0;
      samp_q  <= '0;
      act_q   <= '0;
      vol_q   <= '0;
      mute_q  <= 1'b0;
      acc_q   <= '0;
      y_q     <= '0;
      clipn_q <= 1'b0;
      audio_q <= MID_OUT;
      tick_q  <= 1'b0;
      clip_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= 1'b0;
      clip_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (wrap_w) state_q <= S_SNAP;
        end
        S_SNAP: begin
          samp_q  <= mix.ch_sample;
          act_q   <= mix.ch_active;
          vol_q   <= mix.ch_vol;
          mute_q  <= mix.mute;
          acc_q   <= '0;
          ch_q    <= '0;
          state_q <= S_ACCUM;
        end
        S_ACCUM: begin
          acc_q <= acc_d;
          ch_q  <= ch_q + CW'(1);
          if (last_w) state_q <= S_CLAMP;
        end
        S_CLAMP: begin
          y_q     <= ysat_w;
          clipn_q <= sat_w & ~mute_q;
          state_q <= S_OUT;
        end
        S_OUT: begin
          audio_q <= mute_q ? MID_OUT
                            : {~y_q[OUT_W-1], y_q[OUT_W-2:0]};
          tick_q  <= 1'b1;
          clip_q  <= clipn_q;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign mix.audio_out   = audio_q;
  assign mix.sample_tick = tick_q;
  assign mix.clip        = clip_q;
  assign mix.busy        = (state_q != S_IDLE);

endmodule
